// File: rtl/gelato_arb_pkg.sv
// Shared types and constants for the gelato round-robin arbiter.
package gelato_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic ARB_MODE_RR    = 1'b0;
   localparam logic ARB_MODE_FIXED = 1'b1;

endpackage

// File: rtl/gelato_rr_pick.sv
// Combinational winner selection: circular scan from ptr, or plain lowest-index.
module gelato_rr_pick
   import gelato_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   input  logic                 mode,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   logic [2*NUM_PORTS-1:0] dbl;

   // The upper copy supplies the wrapped-around candidates, so the lowest
   // surviving bit is the circular winner for any port count. Scanning downward
   // lets the lowest qualifying bit be the last assignment.
   always_comb begin
      dbl = {req, req};
      idx = '0;
      for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
         if (dbl[i] && ((mode == ARB_MODE_FIXED) || (i >= int'(ptr)))) begin
            idx = (i >= NUM_PORTS) ? IDX_W'(i - NUM_PORTS) : IDX_W'(i);
         end
      end
   end

   assign found = |req;

endmodule

// File: rtl/gelato_rr_arbiter.sv
// N-way round-robin / fixed-priority arbiter with burst locking and optional beat limit.
module gelato_rr_arbiter
   import gelato_arb_pkg::*;
#(
   parameter int NUM_PORTS     = 4,
   parameter int IDX_W         = $clog2(NUM_PORTS),
   parameter int PRIORITY_MODE = 0,
   parameter int MAX_HOLD      = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req_valid,
   input  logic [NUM_PORTS-1:0] req_last,
   input  logic                 grant_ready,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_idx,
   output logic [NUM_PORTS-1:0] grant_onehot,
   output logic                 beat_fire
);

   localparam int   HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic MODE   = (PRIORITY_MODE == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;

   arb_state_e       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_next;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [HOLD_W-1:0] hold_cnt;
   logic             hold_done;
   logic             release_grant;

   gelato_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .mode  (MODE),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign beat_fire = grant_valid & req_valid[grant_idx] & grant_ready;

   assign hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   // Last beat, beat limit and requester drop all collapse into one release.
   assign release_grant = !req_valid[grant_idx] ||
                          (beat_fire && (req_last[grant_idx] || hold_done));

   assign ptr_next = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         hold_cnt     <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state        <= BUSY;
                  grant_valid  <= 1'b1;
                  grant_idx    <= pick_idx;
                  grant_onehot <= NUM_PORTS'(1) << pick_idx;
                  hold_cnt     <= '0;
               end
            end
            BUSY: begin
               if (beat_fire) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
               // Dropping back to IDLE for one cycle is the intended bubble between grants.
               if (release_grant) begin
                  state        <= IDLE;
                  grant_valid  <= 1'b0;
                  grant_idx    <= '0;
                  grant_onehot <= '0;
                  ptr          <= ptr_next;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gelato_rr_arbiter.sv
// Self-checking bench: four arbiter configurations against a behavioural model.
module tb_gelato_rr_arbiter;

   typedef struct packed {
      logic busy;
      int   gidx;
      int   ptr;
      int   beats;
   } mst_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic nrst = 1'b0;

   logic [3:0][3:0] drq;
   logic [3:0][3:0] dlast;
   logic [3:0]      drdy;
   logic [3:0]      gv;
   logic [3:0][1:0] gi;
   logic [3:0][3:0] goh;
   logic [3:0]      bf;

   logic [3:0] nrq[4];
   logic [3:0] nlast[4];
   logic       nrdy[4];

   mst_t ms[4];
   int   np[4];
   int   nmode[4];
   int   nmh[4];

   int n_chk = 0;
   int n_fail = 0;

   logic rec = 1'b0;
   int   cyc = 0;
   logic obs_v[4][32];
   int   obs_i[4][32];
   logic obs_f[4][32];

   logic [3:0] p2rq[7];
   logic       p2rdy[7];

   always #5 clk = ~clk;

   // A: 4-port round-robin, B: 3-port round-robin, C: 4-port MAX_HOLD=4, D: fixed priority
   gelato_rr_arbiter #(.NUM_PORTS(4)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(drq[0]), .req_last(dlast[0]),
      .grant_ready(drdy[0]), .grant_valid(gv[0]), .grant_idx(gi[0]),
      .grant_onehot(goh[0]), .beat_fire(bf[0]));

   gelato_rr_arbiter #(.NUM_PORTS(3)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(drq[1][2:0]), .req_last(dlast[1][2:0]),
      .grant_ready(drdy[1]), .grant_valid(gv[1]), .grant_idx(gi[1]),
      .grant_onehot(goh[1][2:0]), .beat_fire(bf[1]));
   assign goh[1][3] = 1'b0;

   gelato_rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4)) u_c (
      .clk(clk), .rst_n(rst_n), .req_valid(drq[2]), .req_last(dlast[2]),
      .grant_ready(drdy[2]), .grant_valid(gv[2]), .grant_idx(gi[2]),
      .grant_onehot(goh[2]), .beat_fire(bf[2]));

   gelato_rr_arbiter #(.NUM_PORTS(4), .PRIORITY_MODE(1)) u_d (
      .clk(clk), .rst_n(rst_n), .req_valid(drq[3]), .req_last(dlast[3]),
      .grant_ready(drdy[3]), .grant_valid(gv[3]), .grant_idx(gi[3]),
      .grant_onehot(goh[3]), .beat_fire(bf[3]));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: circular scan by modulo arithmetic, burst bookkeeping as plain integers.
   function automatic mst_t mstep(mst_t s, logic [3:0] rq, logic [3:0] lst, logic rdy,
                                  int n, int md, int mh);
      mst_t r;
      logic fire;
      logic rel;
      logic found;
      r = s;
      found = 1'b0;
      if (!s.busy) begin
         for (int k = 0; k < n; k++) begin
            int c;
            c = (md == 1) ? k : (s.ptr + k) % n;
            if (!found && rq[c]) begin
               found = 1'b1;
               r.busy = 1'b1;
               r.gidx = c;
               r.beats = 0;
            end
         end
      end else begin
         fire = rq[s.gidx] && rdy;
         rel = !rq[s.gidx] || (fire && lst[s.gidx]) || (fire && mh != 0 && s.beats + 1 == mh);
         if (fire) r.beats = s.beats + 1;
         if (rel) begin
            r.busy = 1'b0;
            r.ptr = (s.gidx + 1) % n;
         end
      end
      return r;
   endfunction

   task automatic tick();
      int ev, ei, eoh, ef;
      @(negedge clk);
      rst_n = nrst;
      for (int i = 0; i < 4; i++) begin
         drq[i]   = (np[i] == 3) ? (nrq[i] & 4'b0111) : nrq[i];
         dlast[i] = nlast[i];
         drdy[i]  = nrdy[i];
         if (!rst_n) ms[i] = '0;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         ev  = int'(ms[i].busy);
         ei  = ms[i].busy ? ms[i].gidx : 0;
         eoh = ms[i].busy ? (1 << ms[i].gidx) : 0;
         ef  = (ms[i].busy && drq[i][ms[i].gidx] && drdy[i]) ? 1 : 0;
         chk($sformatf("grant_valid_inst%0d", i), int'(gv[i]), ev);
         chk($sformatf("grant_idx_inst%0d", i), int'(gi[i]), ei);
         chk($sformatf("grant_onehot_inst%0d", i), int'(goh[i]), eoh);
         chk($sformatf("beat_fire_inst%0d", i), int'(bf[i]), ef);
         if (rec && cyc < 32) begin
            obs_v[i][cyc] = gv[i];
            obs_i[i][cyc] = int'(gi[i]);
            obs_f[i][cyc] = bf[i];
         end
         if (rst_n) ms[i] = mstep(ms[i], drq[i], dlast[i], drdy[i], np[i], nmode[i], nmh[i]);
      end
   endtask

   initial begin
      int cnt;
      np    = '{4, 3, 4, 4};
      nmode = '{0, 0, 0, 1};
      nmh   = '{0, 0, 4, 0};
      p2rq  = '{4'hF, 4'hF, 4'h2, 4'h2, 4'h0, 4'hF, 4'hF};
      p2rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      drq = '0; dlast = '0; drdy = '0;
      for (int i = 0; i < 4; i++) begin
         ms[i] = '0; nrq[i] = '0; nlast[i] = '0; nrdy[i] = 1'b0;
      end

      tick();
      tick();
      chk("reset_grant_valid", int'(gv[0]), 0);
      chk("reset_grant_onehot", int'(goh[0]), 0);

      // Directed patterns from a fresh reset
      nrst = 1'b1;
      nrq[0] = 4'b1010; nlast[0] = 4'hF; nrdy[0] = 1'b1;
      nrq[1] = 4'b0111; nlast[1] = 4'hF; nrdy[1] = 1'b1;
      nrq[2] = 4'b0101; nlast[2] = 4'h0;
      nrq[3] = 4'b1111; nlast[3] = 4'hF; nrdy[3] = 1'b1;
      rec = 1'b1;
      for (int j = 0; j < 20; j++) begin
         nrdy[2] = !(j >= 2 && j <= 4);
         cyc = j;
         tick();
      end
      rec = 1'b0;

      for (int j = 0; j < 20; j++) begin
         chk($sformatf("a_valid_c%0d", j), int'(obs_v[0][j]), j % 2);
         chk($sformatf("b_valid_c%0d", j), int'(obs_v[1][j]), j % 2);
         chk($sformatf("d_valid_c%0d", j), int'(obs_v[3][j]), j % 2);
         if (j % 2 == 1) begin
            chk($sformatf("a_idx_c%0d", j), obs_i[0][j], (j % 4 == 1) ? 1 : 3);
            chk($sformatf("b_idx_c%0d", j), obs_i[1][j], ((j - 1) / 2) % 3);
            chk($sformatf("d_idx_c%0d", j), obs_i[3][j], 0);
         end
      end
      cnt = 0;
      for (int j = 0; j <= 12; j++) begin
         if (obs_v[2][j] && obs_f[2][j] && obs_i[2][j] == 0) cnt++;
      end
      chk("c_idx0_fires", cnt, 4);
      chk("c_bubble_valid", int'(obs_v[2][8]), 0);
      chk("c_next_valid", int'(obs_v[2][9]), 1);
      chk("c_next_idx", obs_i[2][9], 2);

      // Asynchronous reset while A holds idx3
      chk("a_busy_before_reset", int'(gv[0]), 1);
      chk("a_idx_before_reset", int'(gi[0]), 3);
      #2;
      rst_n = 1'b0;
      nrst = 1'b0;
      #1;
      chk("async_grant_valid", int'(gv[0]), 0);
      chk("async_grant_idx", int'(gi[0]), 0);
      chk("async_grant_onehot", int'(goh[0]), 0);
      chk("async_beat_fire", int'(bf[0]), 0);
      for (int i = 0; i < 4; i++) begin
         ms[i] = '0; nrq[i] = '0; nlast[i] = 4'hF; nrdy[i] = 1'b1;
      end
      tick();

      // All request after reset, then a granted port drops without a fire
      nrst = 1'b1;
      rec = 1'b1;
      for (int j = 0; j < 7; j++) begin
         for (int i = 0; i < 4; i++) begin
            nrq[i] = p2rq[j];
            nrdy[i] = p2rdy[j];
         end
         cyc = j;
         tick();
      end
      rec = 1'b0;
      chk("p2_first_valid", int'(obs_v[0][1]), 1);
      chk("p2_first_idx", obs_i[0][1], 0);
      chk("p2_stall_idx", obs_i[0][3], 1);
      chk("p2_stall_fire", int'(obs_f[0][3]), 0);
      chk("p2_drop_fire", int'(obs_f[0][4]), 0);
      chk("p2_drop_bubble", int'(obs_v[0][5]), 0);
      chk("p2_after_drop_idx", obs_i[0][6], 2);
      chk("p2_after_drop_valid", int'(obs_v[0][6]), 1);

      // Randomized traffic with persistent requests, stalls and one extra reset
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) begin
               if ($urandom_range(7) == 0) nrq[i][b] = ~nrq[i][b];
               nlast[i][b] = ($urandom_range(2) == 0);
            end
            nrdy[i] = ($urandom_range(3) != 0);
         end
         if (t == 1500) nrst = 1'b0;
         if (t == 1502) nrst = 1'b1;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gelato_rr_arbiter.md
Name: gelato_rr_arbiter

Overview:
Parametrised N-way round-robin arbiter with burst locking, for shared resources such as register-file banks and memory ports.
- Grants one requester, holds the grant across a multi-beat burst, then advances priority past the winner.
- Optional fixed-priority mode and optional per-grant beat limit give starvation control.
- Registered grant outputs with a valid/ready beat handshake toward the shared resource.

Parameters:
NUM_PORTS, 4, number of requesters; must be >= 2; need not be a power of two.
IDX_W, $clog2(NUM_PORTS), width of grant_idx (derived; do not override).
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
MAX_HOLD, 0, maximum beats per grant; 0 = unlimited (release only on last or drop).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_PORTS  per-port request / beat valid.
req_last  input  NUM_PORTS  per-port last-beat marker; sampled only on a fire.
grant_ready  input  1  shared resource accepts the current beat.
grant_valid  output  1  a grant is active.
grant_idx  output  IDX_W  index of the granted port.
grant_onehot  output  NUM_PORTS  one-hot of grant_idx; all zero when grant_valid=0.
beat_fire  output  1  grant_valid & req_valid[grant_idx] & grant_ready.

Behaviour:
- Reset (asynchronous, any cycle including mid-burst):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_valid=0, grant_idx=0, grant_onehot=0, beat_fire=0.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid bit is set, pick the winner and register it: next cycle state=BUSY, grant_valid=1, grant_idx=winner, hold_cnt=0.
  - Round-robin winner: first set bit scanning circularly from ptr upward.
  - Fixed-priority winner: lowest set index; ptr is ignored but still maintained.
  - Latency: request seen in cycle t -> grant_valid=1 in cycle t+1.
  - With no requests, stay IDLE with outputs zero.
- BUSY:
  - grant_idx and grant_onehot are stable for the whole grant.
  - beat_fire is combinational from registered grant state.
  - On each fire, hold_cnt increments (width $clog2(MAX_HOLD+1), minimum 1).
  - Release condition, any of:
    - fire with req_last[grant_idx]=1;
    - fire with MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1;
    - req_valid[grant_idx]=0 (requester dropped).
  - On release: next state=IDLE, grant_valid=0 next cycle, ptr=grant_idx+1, wrapping to 0 when grant_idx==NUM_PORTS-1 (explicit compare, not modulo-2^IDX_W).
  - Releases leave exactly one IDLE bubble cycle. Two grants are never back-to-back; this is deliberate for timing.
  - A requester holding valid without a fire (grant_ready=0) keeps the grant; stalls do not count toward MAX_HOLD.
- When several release conditions hold in the same cycle, a single release occurs; ptr updates once.
- req_last on a non-granted port, or without a fire, is ignored.
- grant_ready is ignored while grant_valid=0.
- New requests arriving in BUSY wait; they are never preempted into the current grant.

Decomposition:
- Package gelato_arb_pkg:
  - arb_state_e (IDLE, BUSY).
  - localparams ARB_MODE_RR=0, ARB_MODE_FIXED=1.
- Sub-module gelato_rr_pick (combinational):
  - Inputs: req, ptr, mode. Outputs: found, idx.
  - Implementation: double-width masked priority encode, so non-power-of-two NUM_PORTS works.
- gelato_rr_arbiter holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- NUM_PORTS=4, req_valid=4'b1010 from cycle 0, grant_ready=1, req_last=1 each beat:
  - grants are idx1 (cycle 1), IDLE (cycle 2), idx3 (cycle 3), IDLE, then idx1 again;
  - ptr sequence 0 -> 2 -> 0 -> 2.
- NUM_PORTS=3, all requesting, single-beat bursts -> grant order 0,1,2,0,1; after idx2, ptr=0 (never 3).
- MAX_HOLD=4, port0 streams with req_last=0, port2 also requesting:
  - exactly 4 beat_fire pulses on idx0, then release;
  - next grant idx2;
  - with grant_ready low for 3 of those cycles, still 4 fires.
- Granted port1 drops req_valid mid-burst with no fire -> grant_valid=0 next cycle, ptr=2, no beat_fire.
- PRIORITY_MODE=1, req_valid=4'b1111 held, single-beat bursts -> every grant is idx0.
- rst_n asserted low mid-BUSY (grant_idx=3) -> outputs zero immediately (asynchronously); after release, the first grant with all ports requesting is idx0.
